// File: rtl/fpga_receiver_if.sv
// rtl/fpga_receiver_if.sv - peer/consumer signal bundle for the serial frame receiver
interface fpga_receiver_if;
   logic       request;
   logic       serialIn;
   logic       finishIn;
   logic       readAck;
   logic       clearError;
   logic       acknowledge;
   logic [7:0] dataOut;
   logic       dataValid;
   logic       frameError;
   logic       busy;

   modport master (
      output request, serialIn, finishIn, readAck, clearError,
      input  acknowledge, dataOut, dataValid, frameError, busy
   );

   modport slave (
      input  request, serialIn, finishIn, readAck, clearError,
      output acknowledge, dataOut, dataValid, frameError, busy
   );
endinterface

// File: rtl/fpga_receiver.sv
// rtl/fpga_receiver.sv - LSB-first serial byte receiver with request/acknowledge framing
module fpga_receiver (
   input  logic           clock,
   input  logic           reset,
   fpga_receiver_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      WAIT_FIN = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;
   logic [3:0] wait_cnt;
   logic       ack_q;
   logic [7:0] data_q;
   logic       valid_q;
   logic       error_q;
   logic       busy_q;

   assign bus.acknowledge = ack_q;
   assign bus.dataOut     = data_q;
   assign bus.dataValid   = valid_q;
   assign bus.frameError  = error_q;
   assign bus.busy        = busy_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         wait_cnt  <= 4'd0;
         ack_q     <= 1'b0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         // Clears come first so an error raised later in this block overrides them
         if (bus.clearError) error_q <= 1'b0;
         if (bus.readAck)    valid_q <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.request && !valid_q) begin
                  state   <= SHIFT;
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  bit_cnt <= 3'd0;
               end
            end

            SHIFT: begin
               if (!bus.request) begin
                  state   <= IDLE;
                  ack_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end else if (bus.finishIn) begin
                  state   <= DONE;
                  ack_q   <= 1'b0;
                  error_q <= 1'b1;
               end else begin
                  shift_reg <= {bus.serialIn, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state    <= WAIT_FIN;
                     wait_cnt <= 4'd0;
                  end
               end
            end

            WAIT_FIN: begin
               if (!bus.request) begin
                  state   <= IDLE;
                  ack_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end else if (bus.finishIn) begin
                  state   <= DONE;
                  ack_q   <= 1'b0;
                  data_q  <= shift_reg;
                  valid_q <= 1'b1;
               end else if (wait_cnt == 4'd15) begin
                  state   <= DONE;
                  ack_q   <= 1'b0;
                  error_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            DONE: begin
               if (!bus.request) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpga_receiver.sv
// tb/tb_fpga_receiver.sv - randomized scoreboard bench for fpga_receiver
module tb_fpga_receiver;

   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   bit         exp_good[$];
   logic [7:0] exp_data[$];
   logic [7:0] last_good;

   fpga_receiver_if bus ();

   fpga_receiver dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic edge_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Outcome of a frame from the edge rules: abort, early finish, good finish, or timeout
   task automatic model(input int fin, input int drop,
                        output bit good, output int end_edge, output bit end_busy);
      good = 0; end_edge = 0; end_busy = 1;
      for (int k = 1; k <= 24; k++) begin
         if (k == drop) begin end_edge = k; end_busy = 0; return; end
         if (k == fin && k <= 8) begin end_edge = k; return; end
         if (k == fin) begin good = 1; end_edge = k; return; end
      end
      end_edge = 24;
   endtask

   task automatic start_frame();
      bus.request = 1'b1;
      edge_step();
      check("ack_at_e0", bus.acknowledge, 1);
      check("busy_at_e0", bus.busy, 1);
   endtask

   task automatic run_bits(input logic [7:0] b, input int fin, input int drop, output bit good);
      int  end_edge, k;
      bit  end_busy;
      model(fin, drop, good, end_edge, end_busy);
      exp_good.push_back(good);
      exp_data.push_back(b);
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         k = i;
         bus.request  = (i == drop) ? 1'b0 : bus.request;
         bus.finishIn = (i == fin);
         bus.serialIn = (i <= 8) ? b[i-1] : 1'($urandom);
         edge_step();
         if (bus.acknowledge == 1'b0) break;
      end
      bus.finishIn = 1'b0;
      bus.serialIn = 1'($urandom);
      check("frame_end_edge", k, end_edge);
      check("busy_after_end", bus.busy, end_busy);
   endtask

   task automatic finish_frame(input bit good);
      bus.request = 1'b0;
      edge_step();
      check("busy_idle", bus.busy, 0);
      if (good) begin
         bus.readAck = 1'b1;
         edge_step();
         bus.readAck = 1'b0;
         check("valid_cleared", bus.dataValid, 0);
      end else begin
         bus.clearError = 1'b1;
         edge_step();
         bus.clearError = 1'b0;
         check("error_cleared", bus.frameError, 0);
      end
   endtask

   // Scoreboard monitor: pops one expected outcome whenever a byte or an error appears
   bit dv_prev = 0, fe_prev = 0;
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.dataValid && !dv_prev) begin
            if (exp_good.size() == 0) check("unexpected_byte", 1, 0);
            else begin
               check("sb_outcome_good", 1, exp_good.pop_front());
               check("sb_data", bus.dataOut, exp_data[0]);
               last_good = exp_data.pop_front();
            end
         end
         if (bus.frameError && !fe_prev) begin
            if (exp_good.size() == 0) check("unexpected_error", 1, 0);
            else begin
               check("sb_outcome_error", 0, exp_good.pop_front());
               void'(exp_data.pop_front());
               check("sb_data_kept", bus.dataOut, last_good);
               check("sb_valid_kept", bus.dataValid, 0);
            end
         end
      end
      dv_prev = bus.dataValid;
      fe_prev = bus.frameError;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      bit         good;
      logic [7:0] b;
      int         fin, drop;

      reset = 1'b1;
      bus.request = 0; bus.serialIn = 0; bus.finishIn = 0; bus.readAck = 0; bus.clearError = 0;
      last_good = 8'h00;
      edge_step();
      edge_step();
      check("rst_ack", bus.acknowledge, 0);
      check("rst_data", bus.dataOut, 8'h00);
      check("rst_valid", bus.dataValid, 0);
      check("rst_error", bus.frameError, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b0;
      edge_step();

      // Known byte 8'hA5 finished on the first WAIT_FIN edge
      start_frame();
      run_bits(8'hA5, 9, 0, good);
      check("a5_data", bus.dataOut, 8'hA5);
      check("a5_valid", bus.dataValid, 1);
      check("a5_ack", bus.acknowledge, 0);

      // Flow control: no acknowledge while the byte is unread
      bus.request = 1'b0;
      edge_step();
      bus.request = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge_step();
         check("ack_withheld", bus.acknowledge, 0);
      end
      bus.readAck = 1'b1;
      edge_step();
      bus.readAck = 1'b0;
      check("ack_same_edge_as_read", bus.acknowledge, 0);
      check("valid_after_read", bus.dataValid, 0);
      edge_step();
      check("ack_after_read", bus.acknowledge, 1);
      run_bits(8'h3C, 12, 0, good);
      finish_frame(good);

      // Early finish at E4
      start_frame();
      run_bits(8'hFF, 4, 0, good);
      check("early_error", bus.frameError, 1);
      check("early_data", bus.dataOut, 8'h3C);
      finish_frame(good);

      // Timeout: no finish for 16 WAIT_FIN edges
      start_frame();
      run_bits(8'h81, 0, 0, good);
      check("timeout_error", bus.frameError, 1);
      check("timeout_done_busy", bus.busy, 1);
      finish_frame(good);

      // Random frames
      for (int n = 0; n < 14; n++) begin
         b    = 8'($urandom);
         fin  = $urandom_range(0, 28);
         drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
         start_frame();
         run_bits(b, fin, drop, good);
         finish_frame(good);
      end

      // Request dropped at E5; error left set for the reset check
      start_frame();
      run_bits(8'h5A, 0, 5, good);
      check("drop_error", bus.frameError, 1);
      check("drop_busy", bus.busy, 0);

      // Reset asserted right after E3 of a new frame
      start_frame();
      for (int i = 1; i <= 2; i++) begin
         bus.serialIn = 1'($urandom);
         edge_step();
      end
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_ack", bus.acknowledge, 0);
      check("midrst_data", bus.dataOut, 8'h00);
      check("midrst_valid", bus.dataValid, 0);
      check("midrst_error", bus.frameError, 0);
      check("midrst_busy", bus.busy, 0);
      last_good = 8'h00;
      @(negedge clock);
      bus.request = 1'b0;
      reset = 1'b0;
      edge_step();
      edge_step();
      check("queue_drained", exp_good.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpga_receiver.md
FPGA_RECEIVER -- requirements
Module: fpga_receiver

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clock.
REQ-003 SHALL have port request  input  1  peer's sendToOther; level, high while the peer wants to send a frame.
REQ-004 SHALL have port serialIn  input  1  peer's serial data line, LSB first.
REQ-005 SHALL have port finishIn  input  1  peer's finish; high marks end of frame.
REQ-006 SHALL have port readAck  input  1  local consumer has taken dataOut (single-cycle pulse).
REQ-007 SHALL have port clearError  input  1  clears frameError.
REQ-008 SHALL have port acknowledge  output  1  registered; high while a frame is accepted and in progress.
REQ-009 SHALL have port dataOut  output  8  last good received byte; held stable while dataValid is high.
REQ-010 SHALL have port dataValid  output  1  dataOut holds an unread byte.
REQ-011 SHALL have port frameError  output  1  sticky error flag.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, SHIFT, WAIT_FIN and DONE, with all outputs registered.
REQ-014 SHALL move IDLE->SHIFT and set acknowledge=1 at the edge (E0) where request=1 and dataValid=0.
REQ-015 SHALL withhold acknowledge in IDLE while dataValid=1 (flow control; the peer waits and no overrun is possible).
REQ-016 SHALL sample serialIn at edges E1..E8 (bit0 at E1, bit7 at E8) into an internal shift register, with a 3-bit counter that wraps 7->0.
REQ-017 SHALL move SHIFT->WAIT_FIN at E8.
REQ-018 SHALL, in WAIT_FIN, on the first edge with finishIn=1: load dataOut from the shift register, set dataValid=1, clear acknowledge, and go to DONE.
REQ-019 SHALL, if 16 edges elapse in WAIT_FIN without finishIn (4-bit timeout counter), set frameError=1, discard the byte, clear acknowledge, and go to DONE.
REQ-020 SHALL treat finishIn=1 during SHIFT as early end: set frameError=1, discard the byte, clear acknowledge, and go to DONE.
REQ-021 SHALL treat request=0 during SHIFT or WAIT_FIN as abort: set frameError=1, discard the byte, clear acknowledge, and go to IDLE.
REQ-022 SHALL stay in DONE until request=0, then go to IDLE; a second frame requires request to fall and rise again.
REQ-023 SHALL clear dataValid at the edge where readAck=1; readAck while dataValid=0 SHALL be ignored.
REQ-024 SHALL never modify dataOut except on a successful frame end (REQ-018).
REQ-025 SHALL clear frameError on clearError=1; a new error on the same edge SHALL win (frameError stays 1).
REQ-026 SHALL let readAck on edge E clear dataValid so that a request present at E+1 is acknowledged at E+1.
REQ-027 SHALL ignore serialIn outside edges E1..E8.

Reset
REQ-028 SHALL, on reset=1, asynchronously force state=IDLE, acknowledge=0, dataOut=8'h00, dataValid=0, frameError=0, busy=0, and clear the counters and shift register.
REQ-029 SHALL make reset asserted mid-frame abort the frame with no dataValid and no frameError.

Verification
REQ-030 Bench SHALL cover: request=1 with bits 1,0,1,0,0,1,0,1 at E1..E8 and finishIn at E9 -> dataOut=8'hA5, dataValid=1 and acknowledge=0 after E9.
REQ-031 Bench SHALL cover: second request while dataValid=1 -> acknowledge stays 0; readAck pulse -> acknowledge=1 on the next edge.
REQ-032 Bench SHALL cover: finishIn=1 at E4 -> frameError=1, dataValid unchanged, dataOut unchanged; clearError -> frameError=0.
REQ-033 Bench SHALL cover: 8 bits received, no finishIn for 16 edges -> frameError=1 and state DONE; request=0 -> IDLE, busy=0.
REQ-034 Bench SHALL cover: request dropped at E5 -> frameError=1, IDLE; reset asserted at E3 of a new frame -> all outputs at reset values before the next edge.
